// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: sequencer state encoding and
// the envelope/frequency constants used at the default 10-bit width.
package synth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_REST    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_NEXT    = 3'd5
    } seq_state_t;

    localparam int ENV_MAX      = 2**10 - 1;
    localparam int FREQ_DEFAULT = 512;

endpackage

// File: rtl/tick_gen.sv
// Envelope/duration prescaler: one-cycle tick every TICK_DIV clocks while
// enabled, phase restarted by clr. TICK_DIV must be at least 2.
module tick_gen #(
    parameter int  TICK_DIV = 100_000,
    localparam int CW       = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Tick is registered one count early so it is high in the cycle before
    // the TICK_DIV-th edge after clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (clr || !en) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == CW'(TICK_DIV - 2));
            cnt_r  <= (cnt_r == CW'(TICK_DIV - 1)) ? '0 : cnt_r + CW'(1);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/note_sequencer.sv
// Step-table note player: drives the oscillator frequency word and applies a
// linear attack/release envelope to the oscillator sample.
module note_sequencer
    import synth_pkg::*;
#(
    parameter int  NBITS    = 10,
    parameter int  STEPS    = 16,
    parameter int  DUR_W    = 16,
    parameter int  TICK_DIV = 100_000,
    parameter int  ENV_STEP = 8,
    localparam int AW       = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [NBITS-1:0] wr_freq,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW-1:0]    last_step,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    input  logic [NBITS-1:0] osc_in,
    output logic [NBITS-1:0] freq_mod,
    output logic [NBITS-1:0] sample_out,
    output logic             busy,
    output logic [AW-1:0]    step_idx,
    output logic             done
);

    localparam logic [NBITS-1:0] ENV_TOP   = {NBITS{1'b1}};
    localparam logic [NBITS:0]   ENV_TOP_W = {1'b0, {NBITS{1'b1}}};
    localparam logic [NBITS:0]   STEP_W    = (NBITS+1)'(ENV_STEP);
    localparam logic [NBITS-1:0] STEP_N    = NBITS'(ENV_STEP);

    logic [NBITS-1:0]   freq_tab_r [STEPS];
    logic [DUR_W-1:0]   dur_tab_r  [STEPS];
    seq_state_t         state_r;
    logic [NBITS-1:0]   env_r;
    logic [NBITS-1:0]   freq_mod_r;
    logic [NBITS-1:0]   sample_r;
    logic [DUR_W-1:0]   dur_cnt_r;
    logic               stop_pend_r;
    logic               busy_r;
    logic               done_r;
    logic [AW-1:0]      step_idx_r;

    logic               tick_s;
    logic               clr_s;
    logic [AW-1:0]      nxt_idx_s;
    logic [AW-1:0]      rd_addr_s;
    logic [NBITS-1:0]   ld_freq_s;
    logic [DUR_W-1:0]   ld_dur_s;
    logic               ld_note_s;
    logic [NBITS:0]     env_sum_s;
    logic               env_sat_s;
    logic [NBITS-1:0]   env_up_s;
    logic [NBITS-1:0]   env_dn_s;
    logic               dur_end_s;
    logic [2*NBITS-1:0] prod_s;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (busy_r),
        .tick  (tick_s)
    );

    // Next-step address, table read, envelope arithmetic and sample product.
    always_comb begin
        nxt_idx_s = (step_idx_r == last_step) ? '0 : step_idx_r + AW'(1);
        rd_addr_s = (state_r == ST_IDLE) ? '0 : nxt_idx_s;
        ld_freq_s = freq_tab_r[rd_addr_s];
        ld_dur_s  = dur_tab_r[rd_addr_s];
        ld_note_s = (ld_freq_s != '0);
        env_sum_s = {1'b0, env_r} + STEP_W;
        env_sat_s = (env_sum_s >= ENV_TOP_W);
        env_up_s  = env_sat_s ? ENV_TOP : env_sum_s[NBITS-1:0];
        env_dn_s  = (env_r > STEP_N) ? env_r - STEP_N : '0;
        dur_end_s = (dur_cnt_r == '0) || (tick_s && (dur_cnt_r == DUR_W'(1)));
        clr_s     = (state_r == ST_IDLE) && start;
        prod_s    = {{NBITS{1'b0}}, osc_in} * {{NBITS{1'b0}}, env_r};
    end

    // Step table; not reset, and a same-cycle read sees the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            freq_tab_r[wr_addr] <= wr_freq;
            dur_tab_r[wr_addr]  <= wr_dur;
        end
    end

    // Sequencer FSM with envelope, duration counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            env_r       <= '0;
            dur_cnt_r   <= '0;
            stop_pend_r <= 1'b0;
            freq_mod_r  <= NBITS'(FREQ_DEFAULT);
            busy_r      <= 1'b0;
            step_idx_r  <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        step_idx_r <= '0;
                        busy_r     <= 1'b1;
                        state_r    <= ld_note_s ? ST_ATTACK : ST_REST;
                        dur_cnt_r  <= ld_dur_s;
                        if (ld_note_s) freq_mod_r <= ld_freq_s;
                    end
                end
                ST_ATTACK, ST_HOLD: begin
                    if (stop) begin
                        stop_pend_r <= 1'b1;
                        state_r     <= ST_RELEASE;
                    end else if (dur_end_s) begin
                        state_r <= ST_RELEASE;
                    end else if (tick_s) begin
                        dur_cnt_r <= dur_cnt_r - DUR_W'(1);
                        if (state_r == ST_ATTACK) begin
                            env_r <= env_up_s;
                            if (env_sat_s) state_r <= ST_HOLD;
                        end
                    end
                end
                ST_REST: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (dur_end_s) begin
                        state_r <= ST_NEXT;
                    end else if (tick_s) begin
                        dur_cnt_r <= dur_cnt_r - DUR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (env_r == '0) begin
                        if (stop_pend_r || stop) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            stop_pend_r <= 1'b0;
                        end else begin
                            state_r <= ST_NEXT;
                        end
                    end else begin
                        if (stop) stop_pend_r <= 1'b1;
                        if (tick_s) env_r <= env_dn_s;
                    end
                end
                ST_NEXT: begin
                    if (!stop && ((step_idx_r != last_step) || loop)) begin
                        step_idx_r <= nxt_idx_s;
                        state_r    <= ld_note_s ? ST_ATTACK : ST_REST;
                        dur_cnt_r  <= ld_dur_s;
                        if (ld_note_s) freq_mod_r <= ld_freq_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        stop_pend_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    stop_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Envelope-scaled sample: upper half of the full-width product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r <= '0;
        end else begin
            sample_r <= prod_s[2*NBITS-1:NBITS];
        end
    end

    assign freq_mod   = freq_mod_r;
    assign sample_out = sample_r;
    assign busy       = busy_r;
    assign step_idx   = step_idx_r;
    assign done       = done_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a note-level timeline model predicts every output
// per clock edge for table-driven sequences, stop, dur=0 and async reset.
module tb_note_sequencer;

    localparam int NB = 10;
    localparam int ST = 16;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int TD = 4;
    localparam int ES = 256;
    localparam int EMAX = 1023;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [NB-1:0] wr_freq = '0;
    logic [DW-1:0] wr_dur = '0;
    logic [AW-1:0] last_step = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [NB-1:0] osc_in = '0;
    logic [NB-1:0] freq_mod;
    logic [NB-1:0] sample_out;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic          done;

    always #5 clk = ~clk;

    note_sequencer #(
        .NBITS(NB), .STEPS(ST), .DUR_W(DW), .TICK_DIV(TD), .ENV_STEP(ES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_dur(wr_dur), .last_step(last_step),
        .loop(loop), .start(start), .stop(stop), .osc_in(osc_in),
        .freq_mod(freq_mod), .sample_out(sample_out), .busy(busy),
        .step_idx(step_idx), .done(done)
    );

    int tf [ST];
    int td [ST];
    int fm_m = 512;
    int last_m = 0;
    bit loop_m = 1'b0;
    int q_busy[$], q_idx[$], q_fm[$], q_env[$], q_done[$];
    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic put(input int b, input int i, input int e, input int dn);
        q_busy.push_back(b);
        q_idx.push_back(i);
        q_fm.push_back(fm_m);
        q_env.push_back(e);
        q_done.push_back(dn);
    endtask

    // Timeline of one sequence; entry c is the state after the c-th edge from start.
    // Ticks land every TD edges counted from the start edge.
    task automatic plan(input int stop_at);
        int c, idx, x, e, env, f, d;
        bit stopped, fin;
        q_busy.delete(); q_idx.delete(); q_fm.delete(); q_env.delete(); q_done.delete();
        c = 0; idx = 0; fin = 1'b0;
        while (!fin) begin
            f = tf[idx];
            d = td[idx];
            if (f != 0) fm_m = f;
            x = (d == 0) ? c + 1 : (c / TD + d) * TD;
            stopped = 1'b0;
            if (stop_at > c && stop_at <= x) begin
                x = stop_at;
                stopped = 1'b1;
            end
            env = 0;
            for (e = c; e < x; e++) begin
                if (f != 0 && e > c && e % TD == 0) env = (env + ES > EMAX) ? EMAX : env + ES;
                put(1, idx, env, 0);
            end
            if (f == 0) begin
                if (stopped) begin
                    put(0, idx, 0, 1);
                    fin = 1'b1;
                end else begin
                    put(1, idx, 0, 0);
                    c = x + 1;
                end
            end else begin
                put(1, idx, env, 0);
                e = x;
                while (env > 0) begin
                    e++;
                    if (e % TD == 0) env = (env > ES) ? env - ES : 0;
                    put(1, idx, env, 0);
                end
                put(stopped ? 0 : 1, idx, 0, stopped ? 1 : 0);
                if (stopped) fin = 1'b1;
                c = e + 2;
            end
            if (!fin) begin
                if (idx != last_m) begin
                    idx++;
                end else if (loop_m) begin
                    idx = 0;
                end else begin
                    put(0, idx, 0, 1);
                    fin = 1'b1;
                end
            end
            if (q_busy.size() > 4000) fin = 1'b1;
        end
    endtask

    task automatic wr(input int a, input int f, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_freq = NB'(f); wr_dur = DW'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        tf[a] = f; td[a] = d;
    endtask

    task automatic setup(input int last, input bit lp);
        last_m = last; loop_m = lp;
        last_step = AW'(last); loop = lp;
    endtask

    task automatic run_seq(input int stop_at, input int wr_k, input int wr_a,
                           input int wr_f, input int wr_d, input int rst_at);
        int osc, envp;
        plan(stop_at);
        for (int k = 0; k < q_busy.size(); k++) begin
            start = (k == 0);
            stop = (k == stop_at);
            wr_en = (k == wr_k);
            if (k == wr_k) begin
                wr_addr = AW'(wr_a); wr_freq = NB'(wr_f); wr_dur = DW'(wr_d);
            end
            osc = (k % 3 == 0) ? EMAX : int'($urandom_range(EMAX));
            osc_in = NB'(osc);
            @(posedge clk); #1;
            envp = (k == 0) ? 0 : q_env[k-1];
            check_eq("busy", busy, q_busy[k]);
            check_eq("freq_mod", freq_mod, q_fm[k]);
            check_eq("step_idx", step_idx, q_idx[k]);
            check_eq("done", done, q_done[k]);
            check_eq("sample", sample_out, (osc * envp) >> NB);
            if (osc == EMAX && envp == EMAX) check_eq("sample_max", sample_out, 1022);
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("rst_freq", freq_mod, 512);
                check_eq("rst_sample", sample_out, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_idx", step_idx, 0);
                check_eq("rst_done", done, 0);
                #1 rst_n = 1'b1;
                fm_m = 512;
                break;
            end
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        if (wr_k >= 0) begin
            tf[wr_a] = wr_f; td[wr_a] = wr_d;
        end
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("idle_busy", busy, 0);
            check_eq("idle_done", done, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < ST; i++) begin
            tf[i] = 0; td[i] = 0;
        end
        #12;
        check_eq("reset_freq", freq_mod, 512);
        check_eq("reset_sample", sample_out, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_idx", step_idx, 0);
        check_eq("reset_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single note; entry 0 rewritten in the start cycle, then replayed.
        wr(0, 100, 10);
        setup(0, 1'b0);
        run_seq(-1, 0, 0, 555, 5, -1);
        run_seq(-1, -1, 0, 0, 0, -1);

        // Note, rest, note.
        wr(0, 200, 2); wr(1, 0, 3); wr(2, 300, 2);
        setup(2, 1'b0);
        run_seq(-1, -1, 0, 0, 0, -1);

        // Looping pair, stopped during HOLD on the second pass of step 0.
        wr(0, 400, 8); wr(1, 250, 3);
        setup(1, 1'b1);
        run_seq(90, -1, 0, 0, 0, -1);

        // Zero-duration note and rest.
        wr(0, 150, 0); wr(1, 0, 0); wr(2, 350, 1);
        setup(2, 1'b0);
        run_seq(-1, -1, 0, 0, 0, -1);

        // Asynchronous reset mid-attack, then replay.
        wr(0, 100, 10);
        setup(0, 1'b0);
        run_seq(-1, -1, 0, 0, 0, 6);
        run_seq(-1, -1, 0, 0, 0, -1);

        // Random short tables.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = 1 + int'($urandom_range(3));
            for (int i = 0; i < n; i++)
                wr(i, ($urandom_range(3) == 0) ? 0 : 1 + int'($urandom_range(1022)),
                   int'($urandom_range(6)));
            setup(n - 1, 1'b0);
            run_seq(-1, -1, 0, 0, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
